axis_submodule_arbiter: RTL
===========================

// Module: axis_submodule_arbiter
// PURPOSE
// - Shares one AXI-Stream egress between NUM_SRC AXI-to-stream submodules (AW/W/AR/R/B taps).
// - Each submodule raises valid, waits for its ready, then streams a packet ending in last.
// - Round-robin grant, held for a whole packet (no interleaving). Checks beat count against submodule length.
// PARAMETERS
// - NUM_SRC     5    number of requesting submodules (2..8)
// - DATA_WIDTH  128  stream data width
// - LEN_WIDTH   6    width of per-source transaction length field
// PORTS
// - clk              in   1                    clock
// - resetn           in   1                    reset, asynchronous assert, active-low
// - src_valid        in   NUM_SRC              per-source packet/beat valid
// - src_last         in   NUM_SRC              per-source last beat of packet
// - src_data         in   NUM_SRC*DATA_WIDTH   per-source beat data, source i at [i*DATA_WIDTH +: DATA_WIDTH]
// - src_len          in   NUM_SRC*LEN_WIDTH    per-source packet length in beats (0 = unchecked)
// - src_ready        out  NUM_SRC              per-source beat accept (one-hot or zero)
// - m_axis_tdata     out  DATA_WIDTH           egress data
// - m_axis_tvalid    out  1                    egress valid
// - m_axis_tlast     out  1                    egress last
// - m_axis_tready    in   1                    egress ready
// - grant_id         out  $clog2(NUM_SRC)      index of current owner (valid when busy=1)
// - busy             out  1                    packet in progress (state != IDLE)
// - len_err          out  1                    sticky length-mismatch flag
// BEHAVIOUR
// - Reset (async, resetn=0): state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, len_err=0.
//   All outputs 0 while in reset; a packet cut by reset is dropped, no recovery beat.
// - FSM IDLE -> [HDR] -> BURST -> IDLE.
// - IDLE: src_ready=0, tvalid=0. If any src_valid, pick first set index starting at rr_ptr (wrapping).
//   Register grant_id and latch src_len[grant] into len_q; enter BURST (or HDR). One-cycle grant latency.
// - BURST: tvalid=src_valid[g], tdata=src_data[g], tlast=src_last[g], src_ready[g]=m_axis_tready.
//   This is a combinational passthrough from the granted source; no added latency.
// - Beat accepted when tvalid&tready: beat_cnt++ (LEN_WIDTH+1 bits, saturating).
// - Accepted beat with tlast: return to IDLE next cycle, rr_ptr=(g+1) mod NUM_SRC, beat_cnt=0.
// - Granted source dropping valid mid-packet: grant held, tvalid=0, no other source served.
// - Length check at the last beat, when len_q!=0: set len_err if (beat_cnt+1)!=len_q.
//   Also set len_err if beat_cnt reaches 2**LEN_WIDTH without last; grant is still held until last.
// - Simultaneous requests: rr_ptr order only. A requester that is refused stays pending; no starvation.
//   Worst-case wait is NUM_SRC-1 packets.
// - Non-granted src_ready always 0. src_ready is never asserted in IDLE or HDR.
// CONFIGURATION
// - ARB_HEADER_EN defined: HDR state inserts one beat before each packet.
//   Header beat: tdata={zeros, grant_id, len_q} (len in [LEN_WIDTH-1:0], id directly above), tlast=0, tvalid=1.
//   HDR stays until tready, then goes to BURST. Header beat is not counted in beat_cnt.
// - ARB_HEADER_EN undefined: no HDR state; IDLE goes directly to BURST. Egress is byte-identical to source packets.
// TESTING
// - Single src: src_valid[2]=1, len=3, 3 beats, last on 3rd, tready=1.
//   Expect grant_id=2 next cycle, 3 egress beats, tlast on 3rd, len_err=0, then IDLE.
// - Contention: src 0,1,4 valid at once, rr_ptr=0, each sends 2-beat packets.
//   Expect grant order 0,1,4, then rr_ptr=0; no interleaved beats.
// - Backpressure: tready toggles 1,0,1,0 during a 4-beat packet.
//   Expect src_ready[g] to mirror tready, 4 beats total accepted, no data loss.
// - Length error: len=4, last arrives on beat 2. Expect len_err=1 (sticky) and return to IDLE.
//   Also len=0 with last on beat 5: len_err stays 0.
// - Reset mid-packet: resetn=0 after beat 1 of 3.
//   Expect all outputs 0 immediately (asynchronous), then IDLE with rr_ptr=0 after release.
// - ARB_HEADER_EN: src 3, len 2. Expect header beat tdata[5:0]=2, tdata[8:6]=3, tlast=0, then 2 data beats.

Source files
------------

// File: rtl/axis_submodule_arbiter_if.sv
// Bundle of the per-source request lanes and the shared AXI-Stream egress.
// The master modport is the arbiter's view; slave is the sources-plus-sink side.
interface axis_submodule_arbiter_if #(
  parameter int NUM_SRC    = 5,
  parameter int DATA_WIDTH = 128,
  parameter int LEN_WIDTH  = 6
);
  logic [NUM_SRC-1:0]            src_valid;
  logic [NUM_SRC-1:0]            src_last;
  logic [NUM_SRC-1:0]            src_ready;
  logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
  logic [NUM_SRC*LEN_WIDTH-1:0]  src_len;
  logic [DATA_WIDTH-1:0]         m_axis_tdata;
  logic                          m_axis_tvalid;
  logic                          m_axis_tlast;
  logic                          m_axis_tready;

  modport master (
    input  src_valid, src_last, src_data, src_len, m_axis_tready,
    output src_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output src_valid, src_last, src_data, src_len, m_axis_tready,
    input  src_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/axis_submodule_arbiter.sv
// Round-robin, packet-atomic arbiter of NUM_SRC stream submodules onto one AXI-Stream egress.
// Define ARB_HEADER_EN to prefix every packet with a {grant_id, len} header beat.
module axis_submodule_arbiter #(
  parameter int NUM_SRC    = 5,
  parameter int DATA_WIDTH = 128,
  parameter int LEN_WIDTH  = 6
) (
  input  logic                       clk,
  input  logic                       resetn,
  axis_submodule_arbiter_if.master   bus,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic                       busy,
  output logic                       len_err
);
  localparam int GW = $clog2(NUM_SRC);
  localparam int CW = LEN_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, HDR, BURST} state_e;

`ifdef ARB_HEADER_EN
  localparam state_e START = HDR;
`else
  localparam state_e START = BURST;
`endif

  state_e               state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        rr_q, rr_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] data_a;
  logic [NUM_SRC-1:0][LEN_WIDTH-1:0]  len_a;
  logic [GW-1:0]                      pick;
  int                                 pick_idx;

  assign data_a = bus.src_data;
  assign len_a  = bus.src_len;

  // Scan downward so the requester closest to rr_q (in wrap order) wins.
  always_comb begin
    pick     = rr_q;
    pick_idx = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      pick_idx = int'(rr_q) + k;
      if (pick_idx >= NUM_SRC) pick_idx = pick_idx - NUM_SRC;
      if (bus.src_valid[pick_idx]) pick = GW'(pick_idx);
    end
  end

  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    rr_d              = rr_q;
    len_d             = len_q;
    cnt_d             = cnt_q;
    err_d             = err_q;
    bus.src_ready     = '0;
    bus.m_axis_tvalid = 1'b0;
    bus.m_axis_tlast  = 1'b0;
    bus.m_axis_tdata  = '0;
    unique case (state_q)
      IDLE: begin
        if (|bus.src_valid) begin
          grant_d = pick;
          len_d   = len_a[pick];
          state_d = START;
        end
      end
`ifdef ARB_HEADER_EN
      HDR: begin
        bus.m_axis_tvalid = 1'b1;
        bus.m_axis_tdata  = DATA_WIDTH'({grant_q, len_q});
        if (bus.m_axis_tready) state_d = BURST;
      end
`endif
      BURST: begin
        bus.m_axis_tvalid       = bus.src_valid[grant_q];
        bus.m_axis_tdata        = data_a[grant_q];
        bus.m_axis_tlast        = bus.src_last[grant_q];
        bus.src_ready[grant_q]  = bus.m_axis_tready;
        if (bus.src_valid[grant_q] && bus.m_axis_tready) begin
          if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
          if (bus.src_last[grant_q]) begin
            // cnt_q + 1 is the beat count including this last beat
            if (len_q != '0 && (cnt_q + CW'(1)) != {1'b0, len_q}) err_d = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
            rr_d    = (grant_q == GW'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
          end else if (cnt_q >= CW'((1 << LEN_WIDTH) - 1)) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);
  assign len_err  = err_q;
endmodule
